// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer.
//   state_t   : one-hot playback state (PAUSED, PLAYING, GAP)
//   next_song : playlist advance with wrap-around at num_songs-1
package song_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_PAUSED  = 3'b001,
    ST_PLAYING = 3'b010,
    ST_GAP     = 3'b100
  } state_t;

  // Advance the song index; the last song of the playlist wraps to 0.
  // With a single-song playlist this always returns 0.
  function automatic logic [1:0] next_song(input logic [1:0] cur,
                                           input int unsigned num_songs);
    if (cur == 2'(num_songs - 1)) begin
      return 2'd0;
    end
    return cur + 2'd1;
  endfunction

endpackage

// File: rtl/song_sequencer_gap_timer.sv
// Beat counter for the silent gap between songs.
//   clk, reset : clock and asynchronous active-low reset
//   clear      : zero the count (taken on entry to the gap)
//   en         : count beats only while enabled
//   beat       : one-cycle tempo tick
//   expired    : the count has reached GAP_BEATS-1, so the next beat ends the gap
module gap_timer #(
  parameter int GAP_BEATS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic beat,
  output logic expired
);

  localparam int CW = $clog2(GAP_BEATS + 1);
  localparam logic [CW-1:0] LAST = CW'(GAP_BEATS - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (en && beat) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/song_sequencer.sv
// Playback controller: selects one of the ROM songs, enables the song
// reader, and inserts a beat-timed silent gap between songs before
// auto-advancing through the playlist.
//   clk, reset   : clock and asynchronous active-low reset
//   play_button  : one-cycle pulse, toggles play/pause
//   next_button  : one-cycle pulse, skip to next song
//   song_done    : pulse from the reader when the last note ends
//   beat         : one-cycle tempo tick
//   play         : reader/note player enable (registered)
//   song         : selected song index (registered)
//   reset_player : one-cycle restart pulse per advance (registered)
//   state_dbg    : current one-hot state, for observation only
//
// Handshake note: every input is a single-cycle pulse sampled on the rising
// edge; there is no back-pressure. Outputs change only after that edge.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int NUM_SONGS    = 4,
  parameter int GAP_BEATS    = 16,
  parameter int AUTO_ADVANCE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play_button,
  input  logic       next_button,
  input  logic       song_done,
  input  logic       beat,
  output logic       play,
  output logic [1:0] song,
  output logic       reset_player,
  output logic [2:0] state_dbg
);

  state_t     state_q, state_d;
  logic [1:0] song_q, song_d;
  logic       reset_player_q;
  logic       play_q, play_d;
  logic       advance;
  logic       gap_clear;
  logic       gap_expired;

  gap_timer #(
    .GAP_BEATS(GAP_BEATS)
  ) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (gap_clear),
    .en      (state_q == ST_GAP),
    .beat    (beat),
    .expired (gap_expired)
  );

  // Priority in every state: next_button first, then play_button / song_done,
  // then beat. A dropped play_button alongside next_button is intentional.
  always_comb begin
    state_d   = state_q;
    advance   = 1'b0;
    gap_clear = 1'b0;
    unique case (state_q)
      ST_PAUSED: begin
        if (next_button) begin
          advance = 1'b1;
        end else if (play_button) begin
          state_d = ST_PLAYING;
        end
      end
      ST_PLAYING: begin
        if (next_button) begin
          advance = 1'b1;
        end else if (song_done) begin
          advance   = 1'b1;
          gap_clear = 1'b1;
          // A pause request in the same cycle skips the gap.
          if (play_button || (AUTO_ADVANCE == 0)) begin
            state_d = ST_PAUSED;
          end else begin
            state_d = ST_GAP;
          end
        end else if (play_button) begin
          state_d = ST_PAUSED;
        end
      end
      ST_GAP: begin
        if (next_button) begin
          advance = 1'b1;
          state_d = ST_PLAYING;
        end else if (play_button) begin
          state_d = ST_PAUSED;
        end else if (beat && gap_expired) begin
          state_d = ST_PLAYING;
        end
      end
      default: begin
        state_d = ST_PAUSED;
      end
    endcase
  end

  always_comb begin
    song_d = advance ? next_song(song_q, NUM_SONGS) : song_q;
    // play is registered from next-state so the reader stays off during
    // its own restart cycle without any combinational output path.
    play_d = (state_d == ST_PLAYING) && !advance;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_PAUSED;
      song_q         <= 2'd0;
      reset_player_q <= 1'b0;
      play_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      song_q         <= song_d;
      reset_player_q <= advance;
      play_q         <= play_d;
    end
  end

  assign play         = play_q;
  assign song         = song_q;
  assign reset_player = reset_player_q;
  assign state_dbg    = state_q;

endmodule
